// File: rtl/pixel_frame_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_frame_streamer_if
//  Description : Pixel stream bus: one 8-bit pixel per beat with valid/ready
//                handshake and start-of-frame / end-of-line / end-of-frame
//                markers that qualify the beat.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pixel_frame_streamer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       sof;
  logic       eol;
  logic       eof;

  modport master (
    output data,
    output valid,
    output sof,
    output eol,
    output eof,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  sof,
    input  eol,
    input  eof,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/pixel_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_frame_streamer
//  Description : Captures a parallel H x W frame on a one-cycle strobe and
//                streams it out one pixel per beat. An active buffer feeds
//                the stream while a pending buffer holds the next frame;
//                frames arriving with both occupied are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_frame_streamer #(
  parameter int H = 4,
  parameter int W = 4,
  parameter int N = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N*8-1:0]         frame_data,
  input  logic                   frame_valid,
  pixel_frame_streamer_if.master m,
  output logic                   busy,
  output logic [7:0]             drop_count
);

  localparam int                c_IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(N - 1);

  // The frame geometry must be consistent; stop elaboration otherwise.
  if (N != H * W) begin : g_size_check
    $error("pixel_frame_streamer: N must equal H*W");
  end

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_idx;
  logic [N*8-1:0]       r_active;
  logic [N*8-1:0]       r_pend_buf;
  logic                 r_pending;
  logic [7:0]           r_drop_count;

  // Output registers, loaded from the next-cycle view of the stream state
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_sof;
  logic                 r_eol;
  logic                 r_eof;
  logic                 r_busy;

  state_t               w_nxt_state;
  logic [c_IDX_W-1:0]   w_nxt_idx;
  logic [N*8-1:0]       w_nxt_active;
  logic [N*8-1:0]       w_nxt_pend_buf;
  logic                 w_nxt_pending;
  logic                 w_nxt_valid;
  logic                 w_drop;
  logic                 w_xfer;
  logic                 w_last;

  assign w_xfer = r_valid & m.ready;
  assign w_last = w_xfer & (r_idx == c_LAST);

  // Decide next buffer contents, index and state from the current beat.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_idx      = r_idx;
    w_nxt_active   = r_active;
    w_nxt_pend_buf = r_pend_buf;
    w_nxt_pending  = r_pending;
    w_drop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_valid) begin
          w_nxt_active = frame_data;
          w_nxt_idx    = '0;
          w_nxt_state  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_last) begin
          w_nxt_idx = '0;
          if (r_pending) begin
            // Pending frame takes over; a coincident strobe refills pending.
            w_nxt_active  = r_pend_buf;
            w_nxt_pending = frame_valid;
            if (frame_valid) begin
              w_nxt_pend_buf = frame_data;
            end
          end else if (frame_valid) begin
            w_nxt_active = frame_data;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end else begin
          if (w_xfer) begin
            w_nxt_idx = r_idx + c_IDX_W'(1);
          end
          if (frame_valid) begin
            if (!r_pending) begin
              w_nxt_pend_buf = frame_data;
              w_nxt_pending  = 1'b1;
            end else begin
              w_drop = 1'b1;
            end
          end
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
    w_nxt_valid = (w_nxt_state == S_STREAM);
  end

  // Register stream state and the outputs derived from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_active     <= '0;
      r_pend_buf   <= '0;
      r_pending    <= 1'b0;
      r_drop_count <= 8'd0;
      r_data       <= 8'd0;
      r_valid      <= 1'b0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_eof        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_active   <= w_nxt_active;
      r_pend_buf <= w_nxt_pend_buf;
      r_pending  <= w_nxt_pending;
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
      r_valid <= w_nxt_valid;
      r_data  <= w_nxt_valid ? w_nxt_active[{w_nxt_idx, 3'b000} +: 8] : 8'd0;
      r_sof   <= w_nxt_valid && (w_nxt_idx == '0);
      r_eol   <= w_nxt_valid && ((32'(w_nxt_idx) % W) == (W - 1));
      r_eof   <= w_nxt_valid && (w_nxt_idx == c_LAST);
      r_busy  <= (w_nxt_state == S_STREAM) || w_nxt_pending;
    end
  end

  assign m.data     = r_data;
  assign m.valid    = r_valid;
  assign m.sof      = r_sof;
  assign m.eol      = r_eol;
  assign m.eof      = r_eof;
  assign busy       = r_busy;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_frame_streamer
//  Description : Bench for pixel_frame_streamer. A frame-level model keeps a
//                queue of accepted frames plus the beat position within the
//                head frame; it predicts every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_streamer;
  localparam int H = 4;
  localparam int W = 4;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*8-1:0] frame_data = '0;
  logic           frame_valid = 1'b0;
  logic           busy;
  logic [7:0]     drop_count;

  pixel_frame_streamer_if mif ();

  pixel_frame_streamer #(.H(H), .W(W), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .m          (mif.master),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfers = 0;
  int last_xfer_cyc = 0;

  // Reference model: frames waiting or in flight, and beat within the head.
  logic [N*8-1:0] mq[$];
  int             beat = 0;
  int             mdrops = 0;

  function automatic logic [N*8-1:0] ramp(input logic [7:0] base);
    logic [N*8-1:0] f;
    for (int k = 0; k < N; k++) f[8*k +: 8] = base + 8'(k);
    return f;
  endfunction

  function automatic logic [N*8-1:0] rnd_frame();
    logic [N*8-1:0] f;
    for (int k = 0; k < N; k++) f[8*k +: 8] = 8'($urandom);
    return f;
  endfunction

  // One clock cycle: compare outputs against the model, drive inputs,
  // advance the model, then wait for the next falling edge.
  task automatic step(input logic fv, input logic [N*8-1:0] fd, input logic rdy);
    logic [N*8-1:0] cur;
    logic           ev;
    logic [7:0]     ed;
    logic           esof, eeol, eeof;
    ev = (mq.size() > 0);
    ed = 8'd0;
    esof = 1'b0; eeol = 1'b0; eeof = 1'b0;
    if (ev) begin
      cur  = mq[0];
      ed   = cur[8*beat +: 8];
      esof = (beat == 0);
      eeol = ((beat % W) == W - 1);
      eeof = (beat == N - 1);
    end
    checks++;
    if (mif.valid !== ev) begin
      failures++;
      $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, mif.valid, ev);
    end
    checks++;
    if (busy !== ev) begin
      failures++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, ev);
    end
    checks++;
    if (drop_count !== 8'(mdrops)) begin
      failures++;
      $display("FAIL drop_count cyc=%0d got=%0d exp=%0d", cyc, drop_count, mdrops);
    end
    checks++;
    if ({mif.sof, mif.eol, mif.eof} !== {esof, eeol, eeof}) begin
      failures++;
      $display("FAIL markers cyc=%0d got sof/eol/eof=%b%b%b exp=%b%b%b",
               cyc, mif.sof, mif.eol, mif.eof, esof, eeol, eeof);
    end
    if (ev) begin
      checks++;
      if (mif.data !== ed) begin
        failures++;
        $display("FAIL data cyc=%0d beat=%0d got=%h exp=%h", cyc, beat, mif.data, ed);
      end
    end
    if (mif.valid === 1'b1 && rdy) begin
      xfers++;
      last_xfer_cyc = cyc;
    end
    frame_valid = fv;
    frame_data  = fd;
    mif.ready   = rdy;
    if (ev && rdy) begin
      beat++;
      if (beat == N) begin
        void'(mq.pop_front());
        beat = 0;
      end
    end
    if (fv) begin
      if (mq.size() < 2) mq.push_back(fd);
      else if (mdrops < 255) mdrops++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while (mq.size() > 0 && n < 200) begin
      step(1'b0, rnd_frame(), 1'b1);
      n++;
    end
    checks++;
    if (mq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d frames exp=0", mq.size());
    end
    step(1'b0, rnd_frame(), 1'b1);
    step(1'b0, rnd_frame(), 1'b1);
  endtask

  task automatic test_reset();
    mif.ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({mif.valid, mif.sof, mif.eol, mif.eof, busy, mif.data, drop_count} !== 21'd0) begin
      failures++;
      $display("FAIL reset_state got valid=%b data=%h busy=%b drops=%0d exp all zero",
               mif.valid, mif.data, busy, drop_count);
    end
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, rnd_frame(), 1'b1);
    step(1'b0, rnd_frame(), 1'b1);
  endtask

  task automatic test_single_frame();
    step(1'b1, ramp(8'h01), 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, rnd_frame(), 1'b1);
  endtask

  task automatic test_backpressure();
    int first_cyc;
    step(1'b1, ramp(8'h01), 1'b1);
    first_cyc = cyc;
    xfers = 0;
    for (int i = 0; i < 40; i++) step(1'b0, rnd_frame(), (i % 2) == 0);
    checks++;
    if (xfers != 16) begin
      failures++;
      $display("FAIL bp_transfers got=%0d exp=16", xfers);
    end
    checks++;
    if (last_xfer_cyc - first_cyc + 1 != 31) begin
      failures++;
      $display("FAIL bp_duration got=%0d exp=31", last_xfer_cyc - first_cyc + 1);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, ramp(8'h01), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, rnd_frame(), 1'b1);
    step(1'b1, ramp(8'h81), 1'b1);
    drain();
    checks++;
    if (drop_count !== 8'd0) begin
      failures++;
      $display("FAIL b2b_drops got=%0d exp=0", drop_count);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, ramp(8'h01), 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, rnd_frame(), 1'b1);
    step(1'b1, ramp(8'h81), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, rnd_frame(), 1'b1);
    step(1'b1, ramp(8'hC1), 1'b1);
    drain();
    checks++;
    if (drop_count !== 8'd1) begin
      failures++;
      $display("FAIL overflow_drops got=%0d exp=1", drop_count);
    end
    step(1'b1, ramp(8'h21), 1'b0);
    step(1'b1, ramp(8'h41), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, rnd_frame(), 1'b0);
    checks++;
    if (drop_count !== 8'd255) begin
      failures++;
      $display("FAIL drop_saturate got=%0d exp=255", drop_count);
    end
    drain();
  endtask

  task automatic test_coincident();
    step(1'b1, ramp(8'h01), 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, rnd_frame(), 1'b1);
    step(1'b1, ramp(8'h61), 1'b1);
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) == 0, rnd_frame(), $urandom_range(0, 3) != 0);
    drain();
  endtask

  task automatic test_reset_mid();
    step(1'b1, ramp(8'h01), 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, rnd_frame(), 1'b1);
    reset = 1'b1;
    #1;
    checks++;
    if ({mif.valid, mif.sof, mif.eol, mif.eof, busy, mif.data, drop_count} !== 21'd0) begin
      failures++;
      $display("FAIL async_reset got valid=%b data=%h busy=%b drops=%0d exp all zero",
               mif.valid, mif.data, busy, drop_count);
    end
    mq.delete();
    beat = 0;
    mdrops = 0;
    frame_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, rnd_frame(), 1'b1);
    step(1'b1, ramp(8'hA1), 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_coincident();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
